// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer and the forwarding unit.
// Pure declarations: no logic, no latency, no flow control.
// Register indices, the per-register stall/clear pair, and the x0 register index.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IF_ID  = 2'd0,
        ID_EX  = 2'd1,
        EX_MEM = 2'd2,
        MEM_WB = 2'd3
    } pipe_reg_e;

    typedef struct packed {
        logic stall;
        logic clear;
    } stage_ctrl_t;

    localparam int          NUM_PIPE_REGS = 4;
    localparam logic [4:0]  REG_X0        = 5'd0;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard detector: a load in EX whose rd is read by the instruction in ID.
// Purely combinational, zero latency.
// No flow control; the caller decides how the hazard is resolved.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    always_comb begin
        load_use = ex_mem_read && (ex_rd != REG_X0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze, redirect, load-use, fetch wait.
// Controls are combinational from inputs plus two state bits; state updates at the next edge.
// A data-memory wait freezes every stage; redirects seen during a freeze are held and replayed.
module pipeline_control
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             pc_stall,
    output logic             stall_if_id,
    output logic             clear_if_id,
    output logic             stall_id_ex,
    output logic             clear_id_ex,
    output logic             stall_ex_mem,
    output logic             clear_ex_mem,
    output logic             stall_mem_wb,
    output logic             clear_mem_wb,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic mem_wait;
    logic fetch_wait;
    logic load_use;
    logic redir;

    logic flush_pending, flush_pending_nxt;
    logic discard, discard_nxt;
    logic redirect_apply;

    stage_ctrl_t [NUM_PIPE_REGS-1:0] ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign mem_wait   = dmem_req & ~dmem_resp;
    assign fetch_wait = imem_req & ~imem_resp;
    assign redir      = ex_redirect | flush_pending;

    always_comb begin
        ctrl              = '0;
        pc_stall          = 1'b0;
        flush_pending_nxt = flush_pending;
        discard_nxt       = discard;
        redirect_apply    = 1'b0;

        if (rst) begin
            for (int i = 0; i < NUM_PIPE_REGS; i++) begin
                ctrl[i].clear = 1'b1;
            end
            flush_pending_nxt = 1'b0;
            discard_nxt       = 1'b0;
        end else if (mem_wait) begin
            for (int i = 0; i < NUM_PIPE_REGS; i++) begin
                ctrl[i].stall = 1'b1;
            end
            pc_stall = 1'b1;
            if (ex_redirect) begin
                flush_pending_nxt = 1'b1;
            end
        end else begin
            // The ID instruction is wrong-path on a redirect, so its load-use is moot.
            if (redir) begin
                ctrl[IF_ID].clear = 1'b1;
                ctrl[ID_EX].clear = 1'b1;
                flush_pending_nxt = 1'b0;
                redirect_apply    = 1'b1;
                if (fetch_wait) begin
                    discard_nxt = 1'b1;
                end
            end else if (load_use) begin
                pc_stall          = 1'b1;
                ctrl[IF_ID].stall = 1'b1;
                ctrl[ID_EX].clear = 1'b1;
            end else if (fetch_wait) begin
                pc_stall          = 1'b1;
                ctrl[IF_ID].clear = 1'b1;
            end

            // Drop the late wrong-path fetch; a held IF/ID defers this to a later response.
            if (discard && imem_resp && !ctrl[IF_ID].stall) begin
                ctrl[IF_ID].clear = 1'b1;
                discard_nxt       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending <= 1'b0;
            discard       <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
        end else begin
            flush_pending <= flush_pending_nxt;
            discard       <= discard_nxt;
            if (pc_stall) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (redirect_apply) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

    assign stall_if_id  = ctrl[IF_ID].stall;
    assign clear_if_id  = ctrl[IF_ID].clear;
    assign stall_id_ex  = ctrl[ID_EX].stall;
    assign clear_id_ex  = ctrl[ID_EX].clear;
    assign stall_ex_mem = ctrl[EX_MEM].stall;
    assign clear_ex_mem = ctrl[EX_MEM].clear;
    assign stall_mem_wb = ctrl[MEM_WB].stall;
    assign clear_mem_wb = ctrl[MEM_WB].clear;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: hand-computed control vectors and counters.
// Control vector order: {pc_stall, stall/clear IF_ID, ID_EX, EX_MEM, MEM_WB}.
module tb_pipeline_control;

    localparam int CNT_W = 32;

    localparam logic [8:0] C_IDLE   = 9'b0_00_00_00_00;
    localparam logic [8:0] C_RESET  = 9'b0_01_01_01_01;
    localparam logic [8:0] C_LDUSE  = 9'b1_10_01_00_00;
    localparam logic [8:0] C_FWAIT  = 9'b1_01_00_00_00;
    localparam logic [8:0] C_FREEZE = 9'b1_10_10_10_10;
    localparam logic [8:0] C_REDIR  = 9'b0_01_01_00_00;
    localparam logic [8:0] C_DROP   = 9'b0_01_00_00_00;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic             imem_req, imem_resp, dmem_req, dmem_resp;
    logic             pc_stall, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex;
    logic             stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [8:0]       ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .imem_req     (imem_req),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .pc_stall     (pc_stall),
        .stall_if_id  (stall_if_id),
        .clear_if_id  (clear_if_id),
        .stall_id_ex  (stall_id_ex),
        .clear_id_ex  (clear_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .clear_ex_mem (clear_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .clear_mem_wb (clear_mem_wb),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    assign ctl = {pc_stall, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
                  stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
        imem_req = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    // Check combinational controls mid-cycle, then advance past the edge.
    task automatic step(input string tag, input logic [8:0] exp_ctl);
        @(negedge clk);
        chk(tag, {23'd0, ctl}, {23'd0, exp_ctl});
        @(posedge clk);
        #1;
    endtask

    task automatic counters(input string tag, input int exp_stall, input int exp_flush);
        chk({tag, "_stall_cycles"}, stall_cycles, exp_stall);
        chk({tag, "_flush_count"}, flush_count, exp_flush);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step("reset_ctl", C_RESET);
        counters("reset", 0, 0);
        rst = 1'b0;
        step("idle", C_IDLE);
        counters("idle", 0, 0);

        // lw x5 in EX, add x6,x5,x1 in ID
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        step("loaduse_rs1", C_LDUSE);
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        step("loaduse_bubble", C_IDLE);
        counters("loaduse", 1, 0);

        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
        step("loaduse_rs2", C_LDUSE);
        id_uses_rs2 = 1'b0;
        step("loaduse_rs2_unused", C_IDLE);

        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        step("load_x0", C_IDLE);
        counters("load_x0", 2, 0);
        idle();

        imem_resp = 1'b0;
        step("fetch_wait_1", C_FWAIT);
        step("fetch_wait_2", C_FWAIT);
        imem_resp = 1'b1;
        step("fetch_done", C_IDLE);
        counters("fetch_wait", 4, 0);

        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1; imem_resp = 1'b0;
        step("loaduse_over_fetch", C_LDUSE);
        idle();

        dmem_req = 1'b1; dmem_resp = 1'b1;
        step("dmem_same_cycle", C_IDLE);
        counters("dmem_same_cycle", 5, 0);

        dmem_resp = 1'b0;
        step("freeze_1", C_FREEZE);
        ex_redirect = 1'b1;
        step("freeze_2_redirect", C_FREEZE);
        ex_redirect = 1'b0;
        step("freeze_3", C_FREEZE);
        dmem_req = 1'b0;
        step("deferred_redirect", C_REDIR);
        counters("deferred", 8, 1);
        step("after_deferred", C_IDLE);

        ex_redirect = 1'b1; imem_resp = 1'b0;
        step("redirect_fetch_busy", C_REDIR);
        ex_redirect = 1'b0;
        step("redirect_fetch_wait", C_FWAIT);
        imem_resp = 1'b1;
        step("discard_response", C_DROP);
        step("discard_consumed", C_IDLE);
        counters("discard", 9, 2);

        ex_redirect = 1'b1; imem_resp = 1'b0;
        step("redirect_again", C_REDIR);
        ex_redirect = 1'b0; imem_resp = 1'b1; dmem_req = 1'b1;
        step("discard_held_in_freeze", C_FREEZE);
        dmem_req = 1'b0;
        step("discard_after_freeze", C_DROP);
        step("discard_done", C_IDLE);
        counters("discard_freeze", 10, 3);

        dmem_req = 1'b1; ex_redirect = 1'b1;
        step("freeze_pending", C_FREEZE);
        ex_redirect = 1'b0;
        rst = 1'b1;
        step("reset_in_freeze", C_RESET);
        counters("reset_in_freeze", 0, 0);
        rst = 1'b0;
        idle();
        step("no_replay_after_reset", C_IDLE);
        counters("post_reset", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the `stall`/`clear` pair of each of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves four sources:
- load-use hazards,
- instruction-memory waits,
- data-memory waits,
- EX-stage control-flow redirects.

It holds registered state so that redirects and wrong-path fetches arriving during a freeze are not lost.

## Interface
Parameters:
- `CNT_W`, 32, width of the performance counters.

Ports (reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_redirect`  in  1  EX resolved a taken branch, jump or mispredict; PC loads the target this cycle.
- `imem_req`, `imem_resp`  in  1 each  fetch request outstanding / response valid.
- `dmem_req`, `dmem_resp`  in  1 each  MEM-stage access outstanding / response valid.
- `pc_stall`  out  1  hold the PC.
- `stall_if_id`, `clear_if_id`  out  1 each  IF/ID register control.
- `stall_id_ex`, `clear_id_ex`  out  1 each  ID/EX register control.
- `stall_ex_mem`, `clear_ex_mem`  out  1 each  EX/MEM register control.
- `stall_mem_wb`, `clear_mem_wb`  out  1 each  MEM/WB register control.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_stall` high.
- `flush_count`  out  CNT_W  count of applied redirects.

## Operation
Derived conditions, evaluated every cycle:
- `mem_wait` = `dmem_req & ~dmem_resp`.
- `fetch_wait` = `imem_req & ~imem_resp`.
- `load_use` = `ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- `redir` = `ex_redirect | flush_pending`.

Priority, highest first:
1. **Freeze** (`mem_wait`): all four stalls high and `pc_stall` high; all clears low.
   - If `ex_redirect` is high during the freeze, set `flush_pending`.
2. **Redirect** (`redir & ~mem_wait`): `clear_if_id` and `clear_id_ex` high; PC not stalled.
   - `flush_pending` is cleared.
   - `flush_count` increments.
   - If `fetch_wait`, set `discard`.
   - Load-use is ignored, because the ID instruction is wrong-path.
3. **Load-use** (`load_use`): `pc_stall`, `stall_if_id` and `clear_id_ex` high, which inserts one bubble. Later stages advance.
4. **Fetch wait** (`fetch_wait`): `pc_stall` and `clear_if_id` high. Later stages advance.
5. Otherwise all outputs low.

Discard rule:
- While `discard=1`, the first cycle with `imem_resp=1` and no freeze forces `clear_if_id` high and clears `discard`. The wrong-path instruction is dropped.
- `discard` persists across freezes.

Other rules:
- A clear is never asserted on a register whose stall is asserted in the same cycle.
- `stall_cycles` increments in every cycle that `pc_stall` is high.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Stall/clear outputs are combinational from the current inputs plus the registered `flush_pending` and `discard`. They take effect at the next clock edge.
- `flush_pending` and `discard` update at the clock edge.
- A deferred redirect is applied in the first cycle with `mem_wait` low; at most one is pending.
- A second `ex_redirect` while one is already pending is impossible, because EX is frozen.

During `rst=1`:
- All four clears high.
- All stalls and `pc_stall` low.
- The pipeline is flushed.

After reset, and on reset asserted mid-freeze or mid-discard:
- `flush_pending`=0, `discard`=0.
- Counters are 0.
- Reset overrides every other condition.

Boundary cases:
- Simultaneous `load_use` and `fetch_wait`: load-use wins, so `stall_if_id` keeps the decoded instruction and `clear_if_id` stays low.
- `ex_rd`=0: never a hazard.
- `dmem_resp` arriving in the same cycle as `dmem_req`: no freeze.

## Structure
- Package `pipeline_ctrl_pkg`:
  - register index enum `IF_ID`/`ID_EX`/`EX_MEM`/`MEM_WB`;
  - packed struct `stage_ctrl_t {stall, clear}`;
  - `REG_X0` constant.
- Sub-module `hazard_detect`: combinational `load_use` computation, reused by the forwarding unit.
- Priority logic and the two state bits stay in the top module.

## Test plan
- **Load-use:** EX `lw x5`, ID `add x6,x5,x1` → exactly one cycle with `pc_stall`=1, `stall_if_id`=1, `clear_id_ex`=1; next cycle all low; `stall_cycles`=1.
- **Load to x0:** `ex_rd`=0 with a matching rs1 → no stall.
- **Redirect during freeze:**
  - Stimulus: `dmem_req`=1 with no response for 3 cycles, and `ex_redirect` pulsed in the 2nd.
  - Required: all stalls high for 3 cycles; `clear_if_id`/`clear_id_ex` high in the 4th cycle; `flush_count`=1.
- **Redirect with fetch in flight:** `ex_redirect` while `imem_req`=1, `imem_resp`=0, then `imem_resp`=1 two cycles later → `clear_if_id` high in the redirect cycle and again in the response cycle.
- **Fetch wait alone:** `imem_resp` low for 2 cycles → `pc_stall`/`clear_if_id` high for those 2 cycles; ID/EX, EX/MEM and MEM/WB controls low.
- **Reset mid-freeze with `flush_pending`=1:** `rst` for 1 cycle → all clears high during reset; afterwards no deferred flush applied and counters read 0.
